bram_req_arbiter: RTL
=====================

BRAM_REQ_ARBITER -- requirements
Module: bram_req_arbiter

Interface
REQ-001 SHALL take parameter N_CH, default 4: number of requesting channels (2..8); channel 0 is the Wishbone CPU port.
REQ-002 SHALL take parameter MAX_OUT, default 11: maximum outstanding memory requests (1..15); matches the BRAM pipeline delay.
REQ-003 SHALL take parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 SHALL have one clock and an asynchronous active-low reset. Ports:
- wb_clk_i  in  1: clock.
- wb_rst_ni  in  1: asynchronous active-low reset.
- req_val  in  N_CH: per-channel request valid.
- req_we  in  N_CH: per-channel write enable.
- req_sel  in  4*N_CH: per-channel byte selects (channel k at [4k+3:4k]).
- req_adr  in  32*N_CH: per-channel byte address.
- req_dat  in  32*N_CH: per-channel write data.
- req_rdy  out  N_CH: one-hot request accepted this cycle.
- rsp_val  out  N_CH: one-hot response valid (read data or write ack).
- rsp_dat  out  32: response data, shared by all channels.
- mem_stb  out  1: memory request strobe.
- mem_we  out  1: memory write.
- mem_sel  out  4: memory byte selects.
- mem_adr  out  32: memory address.
- mem_dat_o  out  32: memory write data.
- mem_ack  in  1: memory response strobe, in issue order.
- mem_dat_i  in  32: memory read data.
- out_cnt  out  4: outstanding request count.
- err  out  1: sticky protocol error.

Function
REQ-005 SHALL compute the grant combinationally each cycle: eligible = req_val AND (out_cnt < MAX_OUT) AND reset deasserted.
REQ-006 SHALL, when eligible is nonzero, assert mem_stb and req_rdy[w] for exactly one winner w, with mem_we/sel/adr/dat_o driven from channel w in the same cycle.
REQ-007 SHALL hold mem_stb=0, req_rdy=0, mem_we=0, mem_sel=0, mem_adr=0 and mem_dat_o=0 when no grant is made.
REQ-008 SHALL, in fixed mode, grant the lowest-index valid channel.
REQ-009 SHALL, in round-robin mode, search from rr_ptr+1 upward with wrap-around, and load rr_ptr with w only on a cycle that makes a grant.
REQ-010 SHALL push w into an in-order tag FIFO of depth MAX_OUT on each grant; a request is transferred exactly when req_val[k] and req_rdy[k] are both high.
REQ-011 SHALL, on mem_ack with out_cnt>0, assert rsp_val[head tag] and pass rsp_dat=mem_dat_i in the same cycle (zero added latency), then pop the head.
REQ-012 SHALL respond to every request, including writes; rsp_dat is don't-care for writes.
REQ-013 SHALL, on push and pop in the same cycle, leave out_cnt unchanged and replace the head/tail entries correctly.
REQ-014 SHALL block issue when full (out_cnt==MAX_OUT) even if mem_ack is high that cycle; there is no combinational path from mem_ack to req_rdy.
REQ-015 SHALL, on mem_ack with out_cnt==0, ignore the ack, assert no rsp_val, and set err=1 until reset.
REQ-016 SHALL drive rsp_val=0 and rsp_dat=0 whenever mem_ack=0.
REQ-017 SHALL implement out_cnt as an up/down counter: +1 on grant, -1 on valid ack, never exceeding MAX_OUT.

Reset
REQ-018 SHALL, while wb_rst_ni=0, clear the tag FIFO pointers, set out_cnt=0, set rr_ptr=N_CH-1 (so channel 0 wins first), set err=0, and force all outputs to 0.
REQ-019 SHALL lose all in-flight tags on a mid-operation reset; acks arriving afterwards with out_cnt==0 fall under REQ-015.

Structure
REQ-020 SHALL place the mode constants (ARB_FIXED=0, ARB_RR=1), the address/data width constants (32), and the tag width in shared package arb_pkg.
REQ-021 SHALL implement the tag FIFO as sub-module arb_tag_fifo (parameters DEPTH and TAG_W; push/pop/full/empty/count ports).

Verification
REQ-022 SHALL cover fixed mode: req_val=4'b1010 held -> ch1 granted every cycle; ch3 starves while ch1 stays valid.
REQ-023 SHALL cover round-robin: req_val=4'b1111 held for 8 cycles with no ack -> grant order 0,1,2,3,0,1,2,3, out_cnt reaches 8.
REQ-024 SHALL cover full: MAX_OUT=11, 11 grants with no ack -> req_rdy=0 and mem_stb=0; a mem_ack in that cycle still blocks issue, and issue resumes the next cycle with out_cnt=10.
REQ-025 SHALL cover in-order routing: ch2 reads 0x3800_0040, then ch0 writes 0x3800_0000; acks return data 0xDEAD_BEEF, then 0 -> rsp_val sequence 4'b0100, then 4'b0001; rsp_dat=0xDEAD_BEEF on the first.
REQ-026 SHALL cover simultaneous push and pop at out_cnt=5 -> out_cnt stays 5 and the response goes to the oldest tag.
REQ-027 SHALL cover error and reset: mem_ack with out_cnt=0 -> err=1 and no rsp_val; wb_rst_ni pulsed low with out_cnt=3 -> out_cnt=0, err=0, and the first grant after release goes to ch0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and helpers for the BRAM request arbiter.
//   ARB_FIXED / ARB_RR : arbitration mode selectors
//   AW / DW            : address and data widths
//   TAG_W              : width of a channel tag (covers up to 8 channels)
//   scan_idx           : channel examined at step i of a priority search
package arb_pkg;
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;
   localparam int AW        = 32;
   localparam int DW        = 32;
   localparam int TAG_W     = 3;

   // Round-robin starts one past the last winner and wraps; fixed scans upward from 0.
   function automatic int scan_idx(input int ptr, input int i, input int n, input bit rr);
      return rr ? (ptr + 1 + i) % n : i;
   endfunction
endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: in-order FIFO of channel tags for outstanding memory requests.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers and count)
//   push, din  : enqueue din (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   head       : oldest tag
//   full/empty : occupancy flags
//   count      : number of stored tags
module arb_tag_fifo #(
   parameter int DEPTH = 11,
   parameter int TAG_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [TAG_W-1:0] din,
   input  logic             pop,
   output logic [TAG_W-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [3:0]       count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [TAG_W-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = count == 4'(DEPTH);
   assign empty   = count == 4'd0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + 4'(do_push) - 4'(do_pop);
      end
   end
endmodule

// File: rtl/bram_req_arbiter.sv
// bram_req_arbiter: multi-channel arbiter in front of a pipelined BRAM, with in-order response routing.
//   wb_clk_i, wb_rst_ni        : clock, asynchronous active-low reset
//   req_val/we/sel/adr/dat     : per-channel request (channel k in slice k)
//   req_rdy                    : one-hot, request of that channel accepted this cycle
//   rsp_val, rsp_dat           : one-hot response strobe, shared response data
//   mem_stb/we/sel/adr/dat_o   : memory request port
//   mem_ack, mem_dat_i         : memory response, returned in issue order
//   out_cnt                    : outstanding request count
//   err                        : sticky flag, ack seen with nothing outstanding
module bram_req_arbiter
   import arb_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int MAX_OUT  = 11,
   parameter int ARB_MODE = 1
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_ni,
   input  logic [N_CH-1:0]    req_val,
   input  logic [N_CH-1:0]    req_we,
   input  logic [4*N_CH-1:0]  req_sel,
   input  logic [AW*N_CH-1:0] req_adr,
   input  logic [DW*N_CH-1:0] req_dat,
   output logic [N_CH-1:0]    req_rdy,
   output logic [N_CH-1:0]    rsp_val,
   output logic [DW-1:0]      rsp_dat,
   output logic               mem_stb,
   output logic               mem_we,
   output logic [3:0]         mem_sel,
   output logic [AW-1:0]      mem_adr,
   output logic [DW-1:0]      mem_dat_o,
   input  logic               mem_ack,
   input  logic [DW-1:0]      mem_dat_i,
   output logic [3:0]         out_cnt,
   output logic               err
);
   logic [N_CH-1:0]  elig;
   logic [TAG_W-1:0] win, rr_ptr, head;
   logic             grant, full, empty, ack_ok;

   // Full is decided from registered state only, so mem_ack never reaches req_rdy.
   assign elig   = req_val & {N_CH{!full && wb_rst_ni}};
   assign ack_ok = mem_ack && !empty && wb_rst_ni;

   always_comb begin
      grant = 1'b0;
      win   = '0;
      for (int i = 0; i < N_CH; i++)
         for (int k = 0; k < N_CH; k++)
            if (!grant && elig[k] && k == scan_idx(int'(rr_ptr), i, N_CH, ARB_MODE == ARB_RR)) begin
               grant = 1'b1;
               win   = TAG_W'(k);
            end
   end

   always_comb begin
      req_rdy   = '0;
      mem_we    = 1'b0;
      mem_sel   = '0;
      mem_adr   = '0;
      mem_dat_o = '0;
      for (int k = 0; k < N_CH; k++)
         if (grant && win == TAG_W'(k)) begin
            req_rdy[k] = 1'b1;
            mem_we     = req_we[k];
            mem_sel    = req_sel[4*k +: 4];
            mem_adr    = req_adr[AW*k +: AW];
            mem_dat_o  = req_dat[DW*k +: DW];
         end
   end

   assign mem_stb = grant;
   assign rsp_val = ack_ok ? N_CH'(1) << head : '0;
   assign rsp_dat = ack_ok ? mem_dat_i : '0;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rr_ptr <= TAG_W'(N_CH - 1);
         err    <= 1'b0;
      end else begin
         if (grant) rr_ptr <= win;
         if (mem_ack && empty) err <= 1'b1;
      end
   end

   arb_tag_fifo #(.DEPTH(MAX_OUT), .TAG_W(TAG_W)) u_fifo (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .push  (grant),
      .din   (win),
      .pop   (ack_ok),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (out_cnt)
   );
endmodule
